irq_timer: RTL and testbench

Memory-mapped 32-bit reload timer that generates the `IRQ` line consumed by the ID-stage decoder of the pipelined MIPS CPU. It responds to MEM-stage `lw`/`sw` accesses on the peripheral bus and raises a level interrupt on counter overflow. The interrupt stays asserted until the handler clears it. The decoder masks nesting through the kernel-mode PC bit, so this block only asserts and holds the level.

---
 rtl/irq_timer_pkg.sv | 19 +
 rtl/irq_timer_prescaler.sv | 36 +++
 rtl/irq_timer.sv | 104 ++++++++++
 tb/tb_irq_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_timer_pkg.sv
// Shared constants for the irq_timer reload timer: register offsets,
// TCON bit positions and reset values.
package irq_timer_pkg;

  localparam logic [31:0] TH_OFS   = 32'd0;
  localparam logic [31:0] TL_OFS   = 32'd4;
  localparam logic [31:0] TCON_OFS = 32'd8;
  localparam logic [31:0] PSC_OFS  = 32'd12;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  localparam logic [31:0] TH_RST   = 32'h0000_0000;
  localparam logic [31:0] TL_RST   = 32'h0000_0000;
  localparam logic [2:0]  TCON_RST = 3'b000;
  localparam logic [15:0] PSC_RST  = 16'h0000;

endpackage

// File: rtl/irq_timer_prescaler.sv
// Tick prescaler for irq_timer: PSC register plus a 16-bit count.
// Only instantiated when IRQ_TIMER_PRESCALE_EN is defined.
module irq_timer_prescaler
  import irq_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        psc_wr,
  input  logic [15:0] psc_wdata,
  output logic [15:0] psc,
  output logic        tick
);

  logic [15:0] psc_q;
  logic [15:0] cnt_q;
  logic        cnt_hit;

  assign cnt_hit = (cnt_q == psc_q);
  assign tick    = en & cnt_hit;
  assign psc     = psc_q;

  // A PSC write restarts the division; disabling freezes the count in place.
  always_ff @(posedge clk) begin
    if (!reset) begin
      psc_q <= PSC_RST;
      cnt_q <= 16'h0000;
    end else if (psc_wr) begin
      psc_q <= psc_wdata;
      cnt_q <= 16'h0000;
    end else if (en) begin
      cnt_q <= cnt_hit ? 16'h0000 : cnt_q + 16'h0001;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// Memory-mapped 32-bit reload timer with level IRQ for the MIPS pipeline.
// Optional prescaler is enabled with `define IRQ_TIMER_PRESCALE_EN.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam logic [31:0] TH_ADDR   = BASE_ADDR + TH_OFS;
  localparam logic [31:0] TL_ADDR   = BASE_ADDR + TL_OFS;
  localparam logic [31:0] TCON_ADDR = BASE_ADDR + TCON_OFS;
  localparam logic [31:0] PSC_ADDR  = BASE_ADDR + PSC_OFS;

  logic [31:0] th_q;
  logic [31:0] tl_q;
  logic [2:0]  tcon_q;
  logic        tick;
  logic        overflow;
  logic        set_is;
  logic        th_wr;
  logic        tl_wr;
  logic        tcon_wr;

  // Bus semantics: MemRead/MemWrite with a full address match is an access;
  // there is no stall, reads complete combinationally, writes at the edge.
  assign th_wr   = MemWrite & (Addr == TH_ADDR);
  assign tl_wr   = MemWrite & (Addr == TL_ADDR);
  assign tcon_wr = MemWrite & (Addr == TCON_ADDR);

`ifdef IRQ_TIMER_PRESCALE_EN
  logic        psc_wr;
  logic [15:0] psc;

  assign psc_wr = MemWrite & (Addr == PSC_ADDR);

  irq_timer_prescaler u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .en        (tcon_q[TCON_EN]),
    .psc_wr    (psc_wr),
    .psc_wdata (WriteData[15:0]),
    .psc       (psc),
    .tick      (tick)
  );
`else
  assign tick = tcon_q[TCON_EN];
`endif

  assign overflow = tick & (tl_q == 32'hFFFF_FFFF);
  assign set_is   = overflow & tcon_q[TCON_IE];
  assign IRQ      = tcon_q[TCON_IE] & tcon_q[TCON_IS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q <= TH_RST;
    end else if (th_wr) begin
      th_q <= WriteData;
    end
  end

  // A CPU write to TL beats the tick; a reload uses TH as it was before this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tl_q <= TL_RST;
    end else if (tl_wr) begin
      tl_q <= WriteData;
    end else if (tick) begin
      tl_q <= overflow ? th_q : tl_q + 32'd1;
    end
  end

  // An overflow on the same edge as a status-clearing write still sets IS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcon_q <= TCON_RST;
    end else if (tcon_wr) begin
      tcon_q <= {WriteData[TCON_IS] | set_is, WriteData[TCON_IE:TCON_EN]};
    end else if (set_is) begin
      tcon_q[TCON_IS] <= 1'b1;
    end
  end

  always_comb begin
    ReadData = 32'h0000_0000;
    if (MemRead) begin
      if (Addr == TH_ADDR)        ReadData = th_q;
      else if (Addr == TL_ADDR)   ReadData = tl_q;
      else if (Addr == TCON_ADDR) ReadData = {29'd0, tcon_q};
`ifdef IRQ_TIMER_PRESCALE_EN
      else if (Addr == PSC_ADDR)  ReadData = {16'd0, psc};
`endif
    end
  end

endmodule

// File: tb/tb_irq_timer.sv
// Directed self-checking bench for irq_timer; prescaler scenario runs
// only when IRQ_TIMER_PRESCALE_EN is defined.
module tb_irq_timer;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE;
  localparam logic [31:0] A_TL  = BASE + 32'd4;
  localparam logic [31:0] A_TC  = BASE + 32'd8;
  localparam logic [31:0] A_PSC = BASE + 32'd12;
  localparam logic [31:0] A_UNM = BASE + 32'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        IRQ;

  int chk_cnt = 0;
  int pass_cnt = 0;

  irq_timer #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .IRQ       (IRQ)
  );

  always #5 clk = ~clk;

  // Called in the low clock phase; the write lands on the next rising edge
  // and the task returns at the following falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    WriteData = d;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    MemRead = 1'b1;
    #1;
    d = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus_read(A_TH, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL reset_th: got %h exp %h", r, 32'h0); else pass_cnt++;
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL reset_tl: got %h exp %h", r, 32'h0); else pass_cnt++;
    bus_read(A_TC, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL reset_tcon: got %h exp %h", r, 32'h0); else pass_cnt++;
    @(negedge clk);
    bus_read(A_UNM, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL unmapped_read: got %h exp %h", r, 32'h0); else pass_cnt++;
    bus_read(A_PSC, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL reset_psc: got %h exp %h", r, 32'h0); else pass_cnt++;
    Addr = A_TH;
    #1;
    chk_cnt++; if (ReadData !== 32'h0) $display("FAIL idle_readdata: got %h exp %h", ReadData, 32'h0); else pass_cnt++;
    chk_cnt++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b exp 0", IRQ); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_overflow_irq();
    logic [31:0] r;
    bus_write(A_TH, 32'hFFFF_FFFD);
    bus_write(A_TL, 32'hFFFF_FFFD);
    bus_write(A_TC, 32'h3);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL ovf_tl0: got %h exp %h", r, 32'hFFFF_FFFD); else pass_cnt++;
    @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'hFFFF_FFFE) $display("FAIL ovf_tl1: got %h exp %h", r, 32'hFFFF_FFFE); else pass_cnt++;
    @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL ovf_tl2: got %h exp %h", r, 32'hFFFF_FFFF); else pass_cnt++;
    chk_cnt++; if (IRQ !== 1'b0) $display("FAIL ovf_irq_early: got %b exp 0", IRQ); else pass_cnt++;
    @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL ovf_reload: got %h exp %h", r, 32'hFFFF_FFFD); else pass_cnt++;
    chk_cnt++; if (IRQ !== 1'b1) $display("FAIL ovf_irq_set: got %b exp 1", IRQ); else pass_cnt++;
    bus_read(A_TC, r);
    chk_cnt++; if (r !== 32'h7) $display("FAIL ovf_tcon: got %h exp %h", r, 32'h7); else pass_cnt++;
    bus_write(A_TC, 32'h3);
    chk_cnt++; if (IRQ !== 1'b0) $display("FAIL irq_clear: got %b exp 0", IRQ); else pass_cnt++;
    bus_read(A_TC, r);
    chk_cnt++; if (r !== 32'h3) $display("FAIL clear_tcon: got %h exp %h", r, 32'h3); else pass_cnt++;
  endtask

  task automatic test_no_ie();
    logic [31:0] r;
    bus_write(A_TC, 32'h0);
    bus_write(A_TH, 32'hFFFF_FFFD);
    bus_write(A_TL, 32'hFFFF_FFFD);
    bus_write(A_TC, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++; if (IRQ !== 1'b0) $display("FAIL noie_irq%0d: got %b exp 0", i, IRQ); else pass_cnt++;
    end
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL noie_reload: got %h exp %h", r, 32'hFFFF_FFFD); else pass_cnt++;
    bus_read(A_TC, r);
    chk_cnt++; if (r !== 32'h1) $display("FAIL noie_tcon: got %h exp %h", r, 32'h1); else pass_cnt++;
  endtask

  task automatic test_clear_collision();
    logic [31:0] r;
    bus_write(A_TC, 32'h0);
    bus_write(A_TH, 32'hFFFF_FFFD);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TC, 32'h3);
    @(negedge clk);
    bus_write(A_TC, 32'h3);
    bus_read(A_TC, r);
    chk_cnt++; if (r !== 32'h7) $display("FAIL coll_tcon: got %h exp %h", r, 32'h7); else pass_cnt++;
    chk_cnt++; if (IRQ !== 1'b1) $display("FAIL coll_irq: got %b exp 1", IRQ); else pass_cnt++;
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL coll_tl: got %h exp %h", r, 32'hFFFF_FFFD); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_tl_write();
    logic [31:0] r;
    bus_write(A_TC, 32'h1);
    bus_write(A_TL, 32'h0000_0010);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h0000_0010) $display("FAIL tlwr_win: got %h exp %h", r, 32'h0000_0010); else pass_cnt++;
    @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h0000_0011) $display("FAIL tlwr_next: got %h exp %h", r, 32'h0000_0011); else pass_cnt++;
  endtask

  task automatic test_th_reload();
    logic [31:0] r;
    bus_write(A_TC, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h0000_0005);
    bus_write(A_TC, 32'h1);
    bus_write(A_TH, 32'h0000_0009);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h0000_0005) $display("FAIL threl_tl: got %h exp %h", r, 32'h0000_0005); else pass_cnt++;
    bus_read(A_TH, r);
    chk_cnt++; if (r !== 32'h0000_0009) $display("FAIL threl_th: got %h exp %h", r, 32'h0000_0009); else pass_cnt++;
    chk_cnt++; if (IRQ !== 1'b0) $display("FAIL threl_irq: got %b exp 0", IRQ); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_rw_same();
    logic [31:0] r;
    bus_write(A_TC, 32'h0);
    Addr = A_TH;
    WriteData = 32'h0000_ABCD;
    MemWrite = 1'b1;
    MemRead = 1'b1;
    #1;
    chk_cnt++; if (ReadData !== 32'h0000_0009) $display("FAIL rw_old: got %h exp %h", ReadData, 32'h0000_0009); else pass_cnt++;
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead = 1'b0;
    bus_read(A_TH, r);
    chk_cnt++; if (r !== 32'h0000_ABCD) $display("FAIL rw_new: got %h exp %h", r, 32'h0000_ABCD); else pass_cnt++;
    bus_write(A_UNM, 32'hFFFF_FFFF);
    bus_read(A_TH, r);
    chk_cnt++; if (r !== 32'h0000_ABCD) $display("FAIL unm_write: got %h exp %h", r, 32'h0000_ABCD); else pass_cnt++;
`ifndef IRQ_TIMER_PRESCALE_EN
    bus_write(A_PSC, 32'h0000_0005);
    bus_read(A_PSC, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL psc_unmapped: got %h exp %h", r, 32'h0); else pass_cnt++;
`endif
    @(negedge clk);
  endtask

`ifdef IRQ_TIMER_PRESCALE_EN
  task automatic test_prescale();
    logic [31:0] r;
    bus_write(A_TC, 32'h0);
    bus_write(A_PSC, 32'h3);
    bus_write(A_TL, 32'h0);
    bus_write(A_TC, 32'h1);
    bus_read(A_PSC, r);
    chk_cnt++; if (r !== 32'h3) $display("FAIL psc_read: got %h exp %h", r, 32'h3); else pass_cnt++;
    repeat (3) @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL psc_tl3: got %h exp %h", r, 32'h0); else pass_cnt++;
    @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h1) $display("FAIL psc_tl4: got %h exp %h", r, 32'h1); else pass_cnt++;
    repeat (4) @(negedge clk);
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h2) $display("FAIL psc_tl8: got %h exp %h", r, 32'h2); else pass_cnt++;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] r;
    bus_write(A_TH, 32'h0000_0077);
    bus_write(A_TC, 32'h3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_read(A_TH, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL rst_mid_th: got %h exp %h", r, 32'h0); else pass_cnt++;
    bus_read(A_TL, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL rst_mid_tl: got %h exp %h", r, 32'h0); else pass_cnt++;
    bus_read(A_TC, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL rst_mid_tcon: got %h exp %h", r, 32'h0); else pass_cnt++;
    bus_read(A_PSC, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL rst_mid_psc: got %h exp %h", r, 32'h0); else pass_cnt++;
    chk_cnt++; if (IRQ !== 1'b0) $display("FAIL rst_mid_irq: got %b exp 0", IRQ); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_overflow_irq();
    test_no_ie();
    test_clear_collision();
    test_tl_write();
    test_th_reload();
    test_rw_same();
`ifdef IRQ_TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
